// File: rtl/counter_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_seq_pkg
//  Description : Shared types and constants for the command-driven counter
//                sequencer: FSM state encoding, count-direction constants and
//                the queued command record.
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_seq_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Count direction carried in cmd_t.dir
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Widest counter supported; the limit field is sized to this and the
    // top zero-extends its WIDTH-bit limit into it.
    localparam int LIMIT_W_MAX = 16;
    localparam int WRAPS_W     = 4;

    // One queued command
    typedef struct packed {
        logic                   dir;
        logic [LIMIT_W_MAX-1:0] limit;
        logic [WRAPS_W-1:0]     wraps;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage : counter_seq_pkg
`default_nettype wire

// File: rtl/counter_seq_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : counter_seq_fifo
//  Description : Synchronous first-in first-out command queue.
//                Ports:
//                  clk, rst        clock, synchronous active-high reset
//                  push, push_data write strobe and data (ignored when full)
//                  pop             read strobe (ignored when empty)
//                  pop_data        head entry, valid whenever !empty
//                  full, empty     occupancy flags, registered-pointer based
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_seq_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4      // power of two, at least 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the
    // address bits coincide.
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_push;
    logic              w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    assign empty    = (r_wr_ptr == r_rd_ptr);
    assign full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign pop_data = r_mem[r_rd_ptr[AW-1:0]];

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule : counter_seq_fifo
`default_nettype wire

// File: rtl/counter_seq.sv
`default_nettype none
// ============================================================================
//  Module      : counter_seq
//  Description : Command-driven up/down wrap counter. Commands (direction,
//                limit, wrap count) are queued in a FIFO and executed one at
//                a time by an IDLE -> LOAD -> RUN state machine.
//                Ports:
//                  clk, rst            clock, synchronous active-high reset
//                  cmd_valid/cmd_ready command handshake (ready = FIFO not full)
//                  cmd_dir             0 count up, 1 count down
//                  cmd_limit           maximum count value
//                  cmd_wraps           wraps to run minus one
//                  abort               terminate the active command
//                  q, q_valid          counter value, high while running
//                  carry, done         wrap pulse, final-wrap pulse
//                  aborted             pulse when an abort takes effect
//                  busy                command active or queued
//                WIDTH must not exceed LIMIT_W_MAX from the package.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_seq
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dir,
    input  logic [WIDTH-1:0]   cmd_limit,
    input  logic [WRAPS_W-1:0] cmd_wraps,
    input  logic               abort,
    output logic [WIDTH-1:0]   q,
    output logic               q_valid,
    output logic               carry,
    output logic               done,
    output logic               aborted,
    output logic               busy
);

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
    cmd_t             w_push_cmd;
    cmd_t             w_head_cmd;
    logic [CMD_W-1:0] w_fifo_dout;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_push;
    logic             w_pop;

    state_t               r_state;
    cmd_t                 r_cmd;
    logic [WIDTH-1:0]     r_q;
    logic [WRAPS_W-1:0]   r_wrap_cnt;
    logic                 r_carry;
    logic                 r_done;
    logic                 r_aborted;

    assign w_push_cmd = '{dir:   cmd_dir,
                          limit: LIMIT_W_MAX'(cmd_limit),
                          wraps: cmd_wraps};
    assign w_head_cmd = cmd_t'(w_fifo_dout);

    // Ready comes straight from the full flag so it never combinationally
    // depends on the pop happening in the same cycle.
    assign cmd_ready = ~w_fifo_full;
    assign w_push    = cmd_valid & ~w_fifo_full;
    assign w_pop     = (r_state == ST_IDLE) & ~w_fifo_empty;

    counter_seq_fifo #(
        .DATA_W (CMD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_cmd),
        .pop       (w_pop),
        .pop_data  (w_fifo_dout),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // Counter datapath helpers
    // ------------------------------------------------------------------
    logic [LIMIT_W_MAX-1:0] w_q_ext;
    logic [WIDTH-1:0]       w_limit;
    logic [WIDTH-1:0]       w_reload;
    logic                   w_at_bound;
    logic                   w_last_wrap;

    assign w_q_ext  = LIMIT_W_MAX'(r_q);
    assign w_limit  = r_cmd.limit[WIDTH-1:0];
    // Value a wrap (or LOAD) returns to: 0 counting up, limit counting down
    assign w_reload = (r_cmd.dir == DIR_DOWN) ? w_limit : '0;
    // The bound is tested before stepping so arithmetic never over/underflows
    assign w_at_bound = (r_cmd.dir == DIR_DOWN) ? (r_q == '0)
                                                : !(w_q_ext < r_cmd.limit);
    assign w_last_wrap = (r_wrap_cnt == r_cmd.wraps);

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cmd      <= '0;
            r_q        <= '0;
            r_wrap_cnt <= '0;
            r_carry    <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
        end else begin
            // Pulses default low; each branch raises what it needs.
            r_carry   <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // q deliberately untouched: it holds its last value here
                    if (!w_fifo_empty) begin
                        r_cmd   <= w_head_cmd;
                        r_state <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (abort) begin
                        r_q       <= '0;
                        r_aborted <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_q        <= w_reload;
                        r_wrap_cnt <= '0;
                        r_state    <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    // Abort wins over any wrap or completion this cycle
                    if (abort) begin
                        r_q       <= '0;
                        r_aborted <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else if (w_at_bound) begin
                        r_q     <= w_reload;
                        r_carry <= 1'b1;
                        if (w_last_wrap) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_wrap_cnt <= r_wrap_cnt + WRAPS_W'(1);
                        end
                    end else if (r_cmd.dir == DIR_DOWN) begin
                        r_q <= r_q - WIDTH'(1);
                    end else begin
                        r_q <= r_q + WIDTH'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign q       = r_q;
    assign q_valid = (r_state == ST_RUN);
    assign carry   = r_carry;
    assign done    = r_done;
    assign aborted = r_aborted;
    assign busy    = (r_state != ST_IDLE) | ~w_fifo_empty;

endmodule : counter_seq
`default_nettype wire

// File: tb/tb_counter_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_seq
//  Description : Self-checking bench for counter_seq: a cycle-by-cycle
//                vector table followed by directed multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dir;
    logic [3:0] cmd_limit;
    logic [3:0] cmd_wraps;
    logic       abort;
    logic [3:0] q;
    logic       q_valid;
    logic       carry;
    logic       done;
    logic       aborted;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    counter_seq #(
        .WIDTH (4),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_limit (cmd_limit),
        .cmd_wraps (cmd_wraps),
        .abort     (abort),
        .q         (q),
        .q_valid   (q_valid),
        .carry     (carry),
        .done      (done),
        .aborted   (aborted),
        .busy      (busy)
    );

    // Record the first q of every command as it enters RUN
    logic [3:0] seen[$];
    logic       prev_qv = 1'b0;
    always @(negedge clk) begin
        if (q_valid && !prev_qv) seen.push_back(q);
        prev_qv = q_valid;
    end

    typedef struct {
        logic       r;
        logic       v;
        logic       d;
        logic [3:0] l;
        logic [3:0] w;
        logic       a;
        logic [3:0] eq;
        logic       eqv;
        logic       ecy;
        logic       edn;
        logic       eab;
        logic       ebs;
        logic       erd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, v, d, input logic [3:0] l, w,
                                input logic a, input logic [3:0] eq,
                                input logic eqv, ecy, edn, eab, ebs, erd);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.l = l; t.w = w; t.a = a;
        t.eq = eq; t.eqv = eqv; t.ecy = ecy; t.edn = edn;
        t.eab = eab; t.ebs = ebs; t.erd = erd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, d, input logic [3:0] l, w);
        cmd_valid = v; cmd_dir = d; cmd_limit = l; cmd_wraps = w;
    endtask

    task automatic do_reset;
        rst = 1'b1; abort = 1'b0; drive(0, 0, 0, 0);
        step;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst = 1'b1; abort = 1'b0; drive(0, 0, 0, 0);

        // ------------------------------------------------------------
        // Vector table: inputs before the edge, outputs after it.
        //        r v d  l  w  a | q qv cy dn ab bs rd
        // ------------------------------------------------------------
        tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,0,1)); // reset
        // up, limit 3, wraps 1
        tbl.push_back(mk(0,1,0,3,1,0, 0,0,0,0,0,1,1)); // push
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,1,1)); // LOAD
        tbl.push_back(mk(0,0,0,0,0,0, 0,1,0,0,0,1,1)); // RUN q=0
        tbl.push_back(mk(0,0,0,0,0,0, 1,1,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,0, 2,1,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,0, 3,1,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,0, 0,1,1,0,0,1,1)); // wrap 1
        tbl.push_back(mk(0,0,0,0,0,0, 1,1,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,0, 2,1,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,0, 3,1,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,1,1,0,0,1)); // final wrap
        tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0,1)); // abort in IDLE ignored
        // down, limit 2, wraps 0
        tbl.push_back(mk(0,1,1,2,0,0, 0,0,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,0, 2,1,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,0, 1,1,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,0, 0,1,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,0, 2,0,1,1,0,0,1)); // wrap + done
        tbl.push_back(mk(0,0,0,0,0,0, 2,0,0,0,0,0,1)); // q holds in IDLE
        // up, limit 0, wraps 2
        tbl.push_back(mk(0,1,0,0,2,0, 2,0,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,0, 2,0,0,0,0,1,1)); // LOAD, q still held
        tbl.push_back(mk(0,0,0,0,0,0, 0,1,0,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,0, 0,1,1,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,0, 0,1,1,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,1,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0,1));

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r; abort = tbl[i].a;
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].w);
            step;
            chk($sformatf("vec%0d {q,qv,cy,dn,ab,bsy,rdy}", i),
                {22'd0, q, q_valid, carry, done, aborted, busy, cmd_ready},
                {22'd0, tbl[i].eq, tbl[i].eqv, tbl[i].ecy, tbl[i].edn,
                 tbl[i].eab, tbl[i].ebs, tbl[i].erd});
        end
        abort = 1'b0; drive(0, 0, 0, 0);

        // ------------------------------------------------------------
        // FIFO fill, back-pressure and ordering
        // ------------------------------------------------------------
        do_reset;
        drive(1, 0, 15, 15); step;          // long command A
        drive(0, 0, 0, 0);   step;          // A popped into LOAD
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 4'(i + 1), 0);
            step;
            chk($sformatf("fill%0d ready", i), cmd_ready, (i == 3) ? 0 : 1);
        end
        drive(1, 1, 5, 0);                  // fifth command held back
        step; step; step;
        chk("full ready held", cmd_ready, 0);
        chk("full A running", q_valid, 1);
        abort = 1'b1; step; abort = 1'b0;
        chk("full abort pulse", aborted, 1);
        seen.delete();
        guard = 0;
        while (!cmd_ready && guard < 10) begin step; guard++; end
        chk("full ready returns", cmd_ready, 1);
        step;                               // fifth command pushed here
        drive(0, 0, 0, 0);
        guard = 0;
        while (busy && guard < 200) begin step; guard++; end
        chk("order drain", busy, 0);
        chk("order count", seen.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < seen.size())
                chk($sformatf("order cmd%0d q", i), seen[i], i + 1);
        end

        // ------------------------------------------------------------
        // Abort mid-run with a queued command behind it
        // ------------------------------------------------------------
        do_reset;
        drive(1, 0, 9, 3); step;
        drive(1, 1, 7, 0); step;
        drive(0, 0, 0, 0);
        guard = 0;
        while (!(q_valid && q == 4'd5) && guard < 50) begin step; guard++; end
        chk("abort reach q5", {q_valid, q}, {1'b1, 4'd5});
        abort = 1'b1; step; abort = 1'b0;
        chk("abort {q,qv,dn,ab,cy}", {q, q_valid, done, aborted, carry},
            {4'd0, 1'b0, 1'b0, 1'b1, 1'b0});
        step;
        chk("abort LOAD {qv,ab,bsy}", {q_valid, aborted, busy}, {1'b0, 1'b0, 1'b1});
        step;
        chk("abort next RUN {qv,q}", {q_valid, q}, {1'b1, 4'd7});
        guard = 0;
        while (busy && guard < 50) begin step; guard++; end

        // Abort must beat a same-cycle wrap/done (limit 0 wraps at once)
        drive(1, 0, 0, 0); step;
        drive(0, 0, 0, 0); step; step;      // LOAD, then RUN q=0
        abort = 1'b1; step; abort = 1'b0;
        chk("abort prio {ab,cy,dn,qv}", {aborted, carry, done, q_valid},
            {1'b1, 1'b0, 1'b0, 1'b0});

        // ------------------------------------------------------------
        // Reset mid-run discards queued commands
        // ------------------------------------------------------------
        do_reset;
        drive(1, 0, 15, 15); step;
        drive(1, 0, 3, 0);   step;
        drive(1, 1, 3, 0);   step;
        drive(0, 0, 0, 0);   step; step;
        chk("rst pre running", {q_valid, busy}, {1'b1, 1'b1});
        rst = 1'b1; step; rst = 1'b0;
        chk("rst {q,qv,cy,dn,ab,bsy,rdy}",
            {q, q_valid, carry, done, aborted, busy, cmd_ready},
            {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        begin
            logic any_run = 1'b0;
            for (int i = 0; i < 10; i++) begin
                step;
                if (q_valid || busy) any_run = 1'b1;
            end
            chk("rst no queued exec", any_run, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_counter_seq
`default_nettype wire
